requant_ser: RTL and testbench
==============================

REQUANT_SER -- requirements
Module: requant_ser

Interface
REQ-001 Parameter OUT_C, default 32, number of channels in one aggregated vector.
REQ-002 Parameter B_WIDTH, default 32, signed width of one aggregated channel word.
REQ-003 Parameter Q_WIDTH, default 8, signed width of one output word.
REQ-004 Parameter SHIFT, default 8, right-shift amount in the range 0..B_WIDTH-1.
REQ-005 Parameter RELU, default 1, where 1 clamps negative inputs to zero before shifting.
REQ-006 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port aggr_pack, input, OUT_C*B_WIDTH bits: aggregated vector; channel k occupies bits [k*B_WIDTH +: B_WIDTH].
REQ-009 Port aggr_valid, input, 1 bit: single-cycle strobe meaning aggr_pack is valid; there is no backpressure to the source.
REQ-010 Port clean, input, 1 bit: synchronous flush.
REQ-011 Port q_data, output, Q_WIDTH bits: requantised channel value.
REQ-012 Port q_chan, output, clog2(OUT_C) bits: channel index of q_data.
REQ-013 Port q_last, output, 1 bit: high when q_chan equals OUT_C-1.
REQ-014 Port q_valid, output, 1 bit: output beat valid.
REQ-015 Port q_ready, input, 1 bit: downstream accepts the beat.
REQ-016 Port busy, output, 1 bit: high when state is SEND or the pending slot is full.
REQ-017 Port overflow, output, 1 bit: sticky flag recording that a vector was dropped.

Function
REQ-018 Storage SHALL consist of a work register, a pending register with a full flag, a channel counter ch, and FSM states IDLE and SEND.
REQ-019 q_valid SHALL be 1 exactly in SEND, with q_chan = ch and q_data = rq(work[ch]).
REQ-020 q_data, q_chan and q_last SHALL be driven only from registers and SHALL hold stable while q_valid=1 and q_ready=0.
REQ-021 rq(x) SHALL use B_WIDTH+1-bit signed arithmetic in this order:
  - if RELU=1 and x<0, substitute 0;
  - if SHIFT>0, add 2^(SHIFT-1);
  - arithmetic right shift by SHIFT;
  - saturate to [-2^(Q_WIDTH-1), 2^(Q_WIDTH-1)-1].
REQ-022 In IDLE, if pending is full, pending SHALL move to work, pending SHALL clear, ch SHALL become 0 and the next state SHALL be SEND.
REQ-023 In IDLE with pending empty, aggr_valid SHALL load aggr_pack into work, set ch=0 and move to SEND, so the first beat is valid on the next cycle.
REQ-024 In SEND, a handshake (q_valid and q_ready) with ch<OUT_C-1 SHALL increment ch.
REQ-025 In SEND, a handshake with ch=OUT_C-1 SHALL, in priority order:
  - load pending into work, set ch=0 and stay in SEND if pending is full;
  - otherwise, if aggr_valid is high, load aggr_pack into work, set ch=0 and stay in SEND;
  - otherwise go to IDLE.
REQ-026 If aggr_valid is not consumed by REQ-023 or REQ-025 and pending is empty, aggr_pack SHALL be stored in pending and pending set full.
REQ-027 If aggr_valid is not consumed and pending is full, the vector SHALL be dropped and overflow set to 1.
REQ-028 The case where pending moves to work on the last handshake while aggr_valid is high SHALL refill pending in the same cycle, with no drop.
REQ-029 clean SHALL set state IDLE, ch=0, pending empty and overflow=0.
REQ-030 clean SHALL override aggr_valid in the same cycle; that vector SHALL be discarded without setting overflow.
REQ-031 Beats SHALL be emitted in channel order 0..OUT_C-1, with no gaps while q_ready=1, and back-to-back vectors SHALL not insert idle cycles.

Reset
REQ-032 rst SHALL force state IDLE, ch=0, pending empty, work cleared, q_valid=0, q_data=0, q_chan=0, q_last=0, busy=0 and overflow=0.
REQ-033 rst SHALL take priority over clean and aggr_valid.
REQ-034 rst asserted mid-vector SHALL abort the vector; no further beats from it SHALL appear.

Verification
REQ-035 Scenario rounding and saturation, with OUT_C=4, SHIFT=8, Q_WIDTH=8, RELU=1, q_ready=1:
  - stimulus: channels {0x180, 0x17F, 0x0001_0000, 0xFFFF_FF00};
  - response: q_data 2, 1, 0x7F, 0x00 on four consecutive cycles, first beat one cycle after aggr_valid;
  - q_last high on the 4th beat only.
REQ-036 Scenario with RELU=0, same other settings:
  - stimulus: channels {0xFFFF_FF00, 0x8000_0000, 0x7FFF_FFFF, 0xFFFF_FF7F};
  - response: q_data 0xFF, 0x80, 0x7F, 0xFF (0x7FFF_FFFF + 128 does not wrap).
REQ-037 Scenario backpressure:
  - stimulus: q_ready toggles 0,1,0,0,1,... during a vector;
  - response: q_data and q_chan stable while stalled; exactly OUT_C beats in order; no duplicates.
REQ-038 Scenario back-to-back plus overflow:
  - stimulus: three aggr_valid strobes on consecutive cycles with q_ready=0;
  - response: first vector in work, second in pending, third dropped, overflow=1, busy=1;
  - after q_ready=1, eight beats total (vectors 1 then 2) with no gap; then clean clears overflow.
REQ-039 Scenario simultaneous events:
  - stimulus: aggr_valid coincides with the last handshake while pending is empty;
  - response: the new vector's channel 0 appears on the next cycle.
  - stimulus: clean coincides with aggr_valid;
  - response: IDLE, q_valid=0, overflow=0.
REQ-040 Scenario reset mid-vector:
  - stimulus: rst asserted after beat 1 of 4, with pending full;
  - response: next cycle q_valid=0, busy=0;
  - response: no beats until a new aggr_valid, whose channel 0 is emitted correctly.

Source files
------------

// File: rtl/requant_ser.sv
// Requantising serialiser: takes one wide vector of accumulator words and emits
// one rounded, shifted, saturated channel per beat. It has a single pending slot.
module requant_ser #(
  parameter int OUT_C   = 32,
  parameter int B_WIDTH = 32,
  parameter int Q_WIDTH = 8,
  parameter int SHIFT   = 8,
  parameter int RELU    = 1,
  localparam int CW     = (OUT_C > 1) ? $clog2(OUT_C) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OUT_C*B_WIDTH-1:0]   aggr_pack,
  input  logic                       aggr_valid,
  input  logic                       clean,
  output logic [Q_WIDTH-1:0]         q_data,
  output logic [CW-1:0]              q_chan,
  output logic                       q_last,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       busy,
  output logic                       overflow
);

  localparam int VW = OUT_C * B_WIDTH;
  localparam logic [CW-1:0] LAST_CH = CW'(OUT_C - 1);
  localparam logic signed [B_WIDTH:0] RND =
    (SHIFT > 0) ? ((B_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [B_WIDTH:0] QMAX = (B_WIDTH+1)'((64'sd1 <<< (Q_WIDTH - 1)) - 64'sd1);
  localparam logic signed [B_WIDTH:0] QMIN = ~QMAX;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_r, state_n;
  logic [CW-1:0]          ch_r, ch_n;
  logic [VW-1:0]          work_r, work_n;
  logic [VW-1:0]          pend_r, pend_n;
  logic                   pend_full_r, pend_full_n;
  logic                   overflow_r, overflow_n;
  logic [Q_WIDTH-1:0]     q_data_r, q_data_n;
  logic [CW-1:0]          q_chan_r;
  logic                   q_last_r, q_valid_r, busy_r;
  logic                   hs_s, take_s;
  logic [B_WIDTH-1:0]     sel_s;

  // Widened by one bit so the rounding add can never wrap before saturation.
  function automatic logic [Q_WIDTH-1:0] rq(input logic [B_WIDTH-1:0] x);
    logic signed [B_WIDTH:0] v;
    v = {x[B_WIDTH-1], x};
    if ((RELU != 0) && v[B_WIDTH]) begin
      v = '0;
    end else begin
      v = v;
    end
    v = (v + RND) >>> SHIFT;
    if (v > QMAX) begin
      rq = QMAX[Q_WIDTH-1:0];
    end else if (v < QMIN) begin
      rq = QMIN[Q_WIDTH-1:0];
    end else begin
      rq = v[Q_WIDTH-1:0];
    end
  endfunction

  assign hs_s = (state_r == SEND) && q_ready;

  // Next-state: work/pending hand-off, channel stepping, pending fill/drop, flush.
  always_comb begin
    state_n     = state_r;
    ch_n        = ch_r;
    work_n      = work_r;
    pend_n      = pend_r;
    pend_full_n = pend_full_r;
    overflow_n  = overflow_r;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_full_r) begin
          work_n      = pend_r;
          pend_full_n = 1'b0;
          ch_n        = '0;
          state_n     = SEND;
        end else if (aggr_valid) begin
          work_n  = aggr_pack;
          ch_n    = '0;
          state_n = SEND;
          take_s  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (!hs_s) begin
          state_n = SEND;
        end else if (ch_r != LAST_CH) begin
          ch_n = ch_r + CW'(1);
        end else if (pend_full_r) begin
          work_n      = pend_r;
          pend_full_n = 1'b0;
          ch_n        = '0;
        end else if (aggr_valid) begin
          work_n = aggr_pack;
          ch_n   = '0;
          take_s = 1'b1;
        end else begin
          ch_n    = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        ch_n    = '0;
      end
    endcase
    // Pending may have just emptied into work, so it refills in the same cycle.
    if (aggr_valid && !take_s) begin
      if (!pend_full_n) begin
        pend_n      = aggr_pack;
        pend_full_n = 1'b1;
      end else begin
        overflow_n = 1'b1;
      end
    end else begin
      pend_n = pend_n;
    end
    if (clean) begin
      state_n     = IDLE;
      ch_n        = '0;
      pend_full_n = 1'b0;
      overflow_n  = 1'b0;
    end else begin
      state_n = state_n;
    end
    sel_s    = work_n[int'(ch_n) * B_WIDTH +: B_WIDTH];
    q_data_n = rq(sel_s);
  end

  // State and registered outputs; the beat is precomputed from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ch_r        <= '0;
      work_r      <= '0;
      pend_r      <= '0;
      pend_full_r <= 1'b0;
      overflow_r  <= 1'b0;
      q_data_r    <= '0;
      q_chan_r    <= '0;
      q_last_r    <= 1'b0;
      q_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      ch_r        <= ch_n;
      work_r      <= work_n;
      pend_r      <= pend_n;
      pend_full_r <= pend_full_n;
      overflow_r  <= overflow_n;
      q_data_r    <= q_data_n;
      q_chan_r    <= ch_n;
      q_last_r    <= (ch_n == LAST_CH);
      q_valid_r   <= (state_n == SEND);
      busy_r      <= (state_n == SEND) || pend_full_n;
    end
  end

  assign q_data   = q_data_r;
  assign q_chan   = q_chan_r;
  assign q_last   = q_last_r;
  assign q_valid  = q_valid_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_requant_ser.sv
// Directed bench for requant_ser with OUT_C=4: one RELU=1 and one RELU=0 instance
// share all inputs.
module tb_requant_ser;

  logic         clk = 1'b0;
  logic         rst, clean, aggr_valid, q_ready;
  logic [127:0] aggr_pack;
  logic [7:0]   q_data1, q_data0;
  logic [1:0]   q_chan1, q_chan0;
  logic         q_last1, q_last0, q_valid1, q_valid0;
  logic         busy1, busy0, overflow1, overflow0;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] pack_a = {32'hFFFF_FF00, 32'h0001_0000, 32'h0000_017F, 32'h0000_0180};
  logic [127:0] pack_n = {32'hFFFF_FF7F, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF00};
  logic [127:0] pack_b = {32'h0000_7F80, 32'h0000_0500, 32'h0000_0000, 32'h0000_0280};
  logic [127:0] pack_c = {32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};
  logic [7:0]   exp_a [4] = '{8'h02, 8'h01, 8'h7F, 8'h00};
  logic [7:0]   exp_n [4] = '{8'hFF, 8'h80, 8'h7F, 8'hFF};
  logic [7:0]   exp_b [4] = '{8'h03, 8'h00, 8'h05, 8'h7F};
  logic [4:0]   rdy_pat = 5'b10010;

  always #5 clk = ~clk;

  requant_ser #(.OUT_C(4), .B_WIDTH(32), .Q_WIDTH(8), .SHIFT(8), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .aggr_pack(aggr_pack), .aggr_valid(aggr_valid), .clean(clean),
    .q_data(q_data1), .q_chan(q_chan1), .q_last(q_last1), .q_valid(q_valid1),
    .q_ready(q_ready), .busy(busy1), .overflow(overflow1)
  );

  requant_ser #(.OUT_C(4), .B_WIDTH(32), .Q_WIDTH(8), .SHIFT(8), .RELU(0)) u_lin (
    .clk(clk), .rst(rst), .aggr_pack(aggr_pack), .aggr_valid(aggr_valid), .clean(clean),
    .q_data(q_data0), .q_chan(q_chan0), .q_last(q_last0), .q_valid(q_valid0),
    .q_ready(q_ready), .busy(busy0), .overflow(overflow0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    int exp_ch;
    rst = 1'b1; clean = 1'b0; aggr_valid = 1'b0; q_ready = 1'b1; aggr_pack = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(q_valid1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ovf", 32'(overflow1), 32'd0);
    chk("rst_data", 32'(q_data1), 32'd0);
    chk("rst_chan", 32'(q_chan1), 32'd0);
    chk("rst_last", 32'(q_last1), 32'd0);

    // rounding and saturation with RELU
    aggr_pack = pack_a; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s1_valid", 32'(q_valid1), 32'd1);
      chk("s1_chan", 32'(q_chan1), 32'(i));
      chk("s1_data", 32'(q_data1), 32'(exp_a[i]));
      chk("s1_last", 32'(q_last1), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("s1_idle", 32'(q_valid1), 32'd0);

    // signed range without RELU
    aggr_pack = pack_n; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s2_chan", 32'(q_chan0), 32'(i));
      chk("s2_data", 32'(q_data0), 32'(exp_n[i]));
      tick();
    end
    chk("s2_idle", 32'(q_valid0), 32'd0);

    // backpressure
    q_ready = 1'b0; aggr_pack = pack_a; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    exp_ch = 0;
    for (int i = 0; i < 20 && exp_ch < 4; i++) begin
      chk("s3_valid", 32'(q_valid1), 32'd1);
      chk("s3_chan", 32'(q_chan1), 32'(exp_ch));
      chk("s3_data", 32'(q_data1), 32'(exp_a[exp_ch]));
      q_ready = rdy_pat[i % 5];
      if (q_ready) exp_ch++;
      tick();
    end
    chk("s3_beats", 32'(exp_ch), 32'd4);
    chk("s3_nodup", 32'(q_valid1), 32'd0);

    // back-to-back with overflow
    q_ready = 1'b0; aggr_valid = 1'b1; aggr_pack = pack_a;
    tick();
    aggr_pack = pack_b;
    tick();
    aggr_pack = pack_c;
    tick();
    aggr_valid = 1'b0;
    chk("s4_ovf", 32'(overflow1), 32'd1);
    chk("s4_busy", 32'(busy1), 32'd1);
    q_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("s4_valid", 32'(q_valid1), 32'd1);
      chk("s4_chan", 32'(q_chan1), 32'(i % 4));
      chk("s4_data", 32'(q_data1), (i < 4) ? 32'(exp_a[i]) : 32'(exp_b[i - 4]));
      tick();
    end
    chk("s4_idle", 32'(q_valid1), 32'd0);
    chk("s4_ovf_sticky", 32'(overflow1), 32'd1);
    clean = 1'b1;
    tick();
    clean = 1'b0;
    chk("s4_clean_ovf", 32'(overflow1), 32'd0);

    // new vector coincides with last handshake
    aggr_pack = pack_a; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    tick(); tick(); tick();
    chk("s5_last", 32'(q_last1), 32'd1);
    aggr_pack = pack_b; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    chk("s5_valid", 32'(q_valid1), 32'd1);
    chk("s5_chan", 32'(q_chan1), 32'd0);
    chk("s5_data", 32'(q_data1), 32'(exp_b[0]));
    tick(); tick(); tick(); tick();
    chk("s5_idle", 32'(q_valid1), 32'd0);
    // clean beats aggr_valid
    clean = 1'b1; aggr_valid = 1'b1; aggr_pack = pack_a;
    tick();
    clean = 1'b0; aggr_valid = 1'b0;
    chk("s5_cl_valid", 32'(q_valid1), 32'd0);
    chk("s5_cl_ovf", 32'(overflow1), 32'd0);
    chk("s5_cl_busy", 32'(busy1), 32'd0);
    tick();
    chk("s5_cl_drop", 32'(q_valid1), 32'd0);

    // reset mid-vector with pending full
    q_ready = 1'b0; aggr_pack = pack_a; aggr_valid = 1'b1;
    tick();
    aggr_pack = pack_b;
    tick();
    aggr_valid = 1'b0; q_ready = 1'b1;
    tick();
    chk("s6_beat1", 32'(q_chan1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_valid", 32'(q_valid1), 32'd0);
    chk("s6_busy", 32'(busy1), 32'd0);
    tick();
    chk("s6_quiet1", 32'(q_valid1), 32'd0);
    tick();
    chk("s6_quiet2", 32'(q_valid1), 32'd0);
    aggr_pack = pack_b; aggr_valid = 1'b1;
    tick();
    aggr_valid = 1'b0;
    chk("s6_new_valid", 32'(q_valid1), 32'd1);
    chk("s6_new_chan", 32'(q_chan1), 32'd0);
    chk("s6_new_data", 32'(q_data1), 32'(exp_b[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
